phy_deser_n: RTL and testbench
==============================

PHY_DESER_N -- requirements
Module: phy_deser_n

Interface
REQ-001 Parameter WIDTH, default 8: bits per symbol/word.
REQ-002 Parameter NUM_LANES, default 4: number of parallel output lanes (>=1).
REQ-003 Parameter COMMA, default 8'hBC: alignment symbol, WIDTH bits.
REQ-004 Parameter IDLE, default 8'h7C: idle symbol, WIDTH bits.
REQ-005 Parameter LOCK_COUNT, default 4: consecutive aligned COMMAs required for lock (>=1).
REQ-006 clk_32f  in  1  sole clock, one serial bit per rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 data_in  in  1  serial bit stream, MSB of each symbol first.
REQ-009 resync  in  1  synchronous request to drop lock and re-search.
REQ-010 data_rx  out  NUM_LANES*WIDTH  lane L occupies bits [L*WIDTH +: WIDTH].
REQ-011 valid_rx  out  NUM_LANES  bit L pulses one cycle when lane L gets a new word.
REQ-012 active  out  1  high while locked (ACTIVE state).
REQ-013 idle_out  out  1  one-cycle pulse per IDLE received while ACTIVE.

Function
REQ-014 Shift register sr SHALL load {sr[WIDTH-2:0], data_in} every edge; "word" below means that new value.
REQ-015 FSM SHALL have states SEARCH, COUNT, ACTIVE.
REQ-016 SEARCH: each edge, word==COMMA -> COUNT, bit_cnt<=0, comma_cnt<=1; otherwise stay.
REQ-017 In COUNT and ACTIVE, bit_cnt SHALL increment modulo WIDTH; a word boundary is an edge with bit_cnt==WIDTH-1.
REQ-018 COUNT, at a boundary: word==COMMA increments comma_cnt; on reaching LOCK_COUNT -> ACTIVE, lane_ptr<=0; word!=COMMA -> SEARCH, comma_cnt<=0.
REQ-019 LOCK_COUNT==1 SHALL enter ACTIVE directly from the SEARCH match.
REQ-020 ACTIVE, at a boundary: COMMA -> lane_ptr<=0, no valid; IDLE -> idle_out pulse, lane_ptr unchanged, no valid; otherwise data_rx lane lane_ptr <= word, valid_rx[lane_ptr] pulses, lane_ptr increments, wrapping NUM_LANES-1 -> 0.
REQ-021 Latency: valid_rx/idle_out SHALL be high for exactly the cycle following the edge that samples the word's last bit.
REQ-022 At most one valid_rx bit SHALL be high in any cycle; no output pulses outside boundaries.
REQ-023 data_rx lanes SHALL hold their last value until overwritten.
REQ-024 active SHALL be registered, rising the cycle after the locking boundary and falling the cycle after leaving ACTIVE.
REQ-025 resync=1 SHALL, at that edge, force SEARCH, clear comma_cnt, bit_cnt, lane_ptr, suppress any pulse due that edge; resync takes priority over a simultaneous boundary.
REQ-026 resync SHALL NOT clear data_rx.

Reset
REQ-027 reset low SHALL asynchronously force SEARCH; sr, bit_cnt, comma_cnt, lane_ptr, data_rx, valid_rx, active, idle_out all 0.
REQ-028 First bit after reset release SHALL be sampled on the first rising edge with reset high; reset mid-word discards the partial word.

Structure
REQ-029 Shared package phy_pkg SHALL hold state encoding and default COMMA/IDLE constants for tx and rx blocks.
REQ-030 Alignment logic (sr, bit_cnt, comma_cnt, FSM) SHALL be sub-module phy_word_align, outputting word, boundary strobe, active; the top holds lane demux.
REQ-031 Counter widths SHALL be $clog2 of range, minimum 1 bit.

Verification (WIDTH=8, NUM_LANES=4, LOCK_COUNT=4)
REQ-032 3 random bits then 4x 0xBC -> active rises cycle after 32nd comma bit; no valid_rx.
REQ-033 Locked, send 0x11,0x22,0x33,0x44,0x55 -> valid_rx 0001,0010,0100,1000,0001; data_rx lane0=0x55, lanes1-3=0x22,0x33,0x44.
REQ-034 Locked, send 0x11,0x7C,0x22,0xBC,0x33 -> lane0=0x11, idle_out pulse, lane1=0x22, lane_ptr reset, lane0=0x33.
REQ-035 2x 0xBC then 0xA5 -> stays inactive, back to SEARCH; 4 further 0xBC -> active.
REQ-036 Locked, assert resync one cycle on a boundary carrying 0x66 -> no valid, active falls next cycle, data_rx unchanged.
REQ-037 Reset low mid-word while ACTIVE -> all outputs 0 immediately; relock needs 4 fresh commas.

Source files
------------

// File: rtl/phy_pkg.sv
// Shared PHY definitions for the tx and rx paths: FSM encoding, default control symbols
// and a counter-width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package phy_pkg;

  // Alignment FSM encoding. Kept as plain constants so legacy blocks can share it.
  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_COUNT  = 2'd1;
  localparam logic [1:0] ST_ACTIVE = 2'd2;

  // Default control symbols for 8-bit symbol streams.
  localparam logic [7:0] DEF_COMMA = 8'hBC;
  localparam logic [7:0] DEF_IDLE  = 8'h7C;

  // Width of a counter that must hold range_n distinct values. The result is never below 1 bit.
  function automatic int cnt_w(input int range_n);
    return (range_n > 1) ? $clog2(range_n) : 1;
  endfunction

endpackage

// File: rtl/phy_word_align.sv
// Serial-to-word aligner. It hunts for COMMA bit by bit, confirms LOCK_COUNT aligned commas
// and then marks every WIDTH-th bit as a word boundary.
// Latency: word and boundary are combinational on the sampling edge; active is registered
// and changes one cycle after the state change.
// Backpressure: none. The block consumes one bit per clk_32f edge unconditionally.
// Ports: clk_32f/reset (clock, async active-low reset), data_in (serial bit, MSB first),
//        resync (drop lock), word (shift window including this edge's bit),
//        boundary (this edge completes a word while locked), active (locked flag).
module phy_word_align
  import phy_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] COMMA      = DEF_COMMA,
  parameter int               LOCK_COUNT = 4
) (
  input  logic             clk_32f,
  input  logic             reset,
  input  logic             data_in,
  input  logic             resync,
  output logic [WIDTH-1:0] word,
  output logic             boundary,
  output logic             active
);

  localparam int              BW       = cnt_w(WIDTH);
  localparam int              CW       = cnt_w(LOCK_COUNT + 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0]   BIT_ONE  = BW'(1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   LOCK_N   = CW'(LOCK_COUNT);

  logic [WIDTH-1:0] sr;
  logic [1:0]       state, state_nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [CW-1:0]    comma_cnt, comma_cnt_nxt;
  logic             at_last_bit;
  logic             is_comma;
  logic             sr_msb_unused;

  // The oldest bit is shifted out of the window on each edge, so it never reaches a consumer.
  assign sr_msb_unused = sr[WIDTH-1];

  assign word        = {sr[WIDTH-2:0], data_in};
  assign is_comma    = (word == COMMA);
  assign at_last_bit = (bit_cnt == BIT_LAST);
  // Only locked boundaries reach the lane demux. A resync on the same edge cancels the boundary.
  assign boundary    = (state == ST_ACTIVE) && at_last_bit && !resync;

  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    comma_cnt_nxt = comma_cnt;
    if (resync) begin
      state_nxt     = ST_SEARCH;
      bit_cnt_nxt   = '0;
      comma_cnt_nxt = '0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (is_comma) begin
            bit_cnt_nxt   = '0;
            comma_cnt_nxt = CNT_ONE;
            state_nxt     = (LOCK_COUNT == 1) ? ST_ACTIVE : ST_COUNT;
          end
        end
        ST_COUNT: begin
          bit_cnt_nxt = at_last_bit ? '0 : bit_cnt + BIT_ONE;
          if (at_last_bit) begin
            if (is_comma) begin
              comma_cnt_nxt = comma_cnt + CNT_ONE;
              if (comma_cnt + CNT_ONE == LOCK_N) state_nxt = ST_ACTIVE;
            end else begin
              state_nxt     = ST_SEARCH;
              comma_cnt_nxt = '0;
            end
          end
        end
        ST_ACTIVE: begin
          bit_cnt_nxt = at_last_bit ? '0 : bit_cnt + BIT_ONE;
        end
        default: begin
          state_nxt = ST_SEARCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      sr        <= '0;
      state     <= ST_SEARCH;
      bit_cnt   <= '0;
      comma_cnt <= '0;
      active    <= 1'b0;
    end else begin
      sr        <= word;
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      comma_cnt <= comma_cnt_nxt;
      active    <= (state_nxt == ST_ACTIVE);
    end
  end

endmodule

// File: rtl/phy_deser_n.sv
// Serial deserializer. It aligns on COMMA and then spreads each data word round-robin over
// NUM_LANES output lanes.
// Latency: valid_rx/idle_out pulse in the cycle after the edge that samples a word's last bit.
// Backpressure: none. The outputs are pulses and lanes hold their values until overwritten.
// Ports: clk_32f/reset (clock, async active-low reset), data_in (serial bit, MSB first),
//        resync (drop lock), data_rx (lane L at [L*WIDTH +: WIDTH]), valid_rx (per-lane strobe),
//        active (locked), idle_out (IDLE received while locked).
module phy_deser_n
  import phy_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               NUM_LANES  = 4,
  parameter logic [WIDTH-1:0] COMMA      = DEF_COMMA,
  parameter logic [WIDTH-1:0] IDLE       = DEF_IDLE,
  parameter int               LOCK_COUNT = 4
) (
  input  logic                       clk_32f,
  input  logic                       reset,
  input  logic                       data_in,
  input  logic                       resync,
  output logic [NUM_LANES*WIDTH-1:0] data_rx,
  output logic [NUM_LANES-1:0]       valid_rx,
  output logic                       active,
  output logic                       idle_out
);

  localparam int            LW        = cnt_w(NUM_LANES);
  localparam logic [LW-1:0] LAST_LANE = LW'(NUM_LANES - 1);
  localparam logic [LW-1:0] LANE_ONE  = LW'(1);

  logic [WIDTH-1:0] word;
  logic             boundary;
  logic [LW-1:0]    lane_ptr;

  phy_word_align #(
    .WIDTH      (WIDTH),
    .COMMA      (COMMA),
    .LOCK_COUNT (LOCK_COUNT)
  ) u_align (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .resync   (resync),
    .word     (word),
    .boundary (boundary),
    .active   (active)
  );

  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      data_rx  <= '0;
      valid_rx <= '0;
      idle_out <= 1'b0;
      lane_ptr <= '0;
    end else begin
      valid_rx <= '0;
      idle_out <= 1'b0;
      // While not locked the pointer is held at lane 0, so every lock starts on lane 0.
      if (resync || !active) begin
        lane_ptr <= '0;
      end else if (boundary) begin
        if (word == COMMA) begin
          lane_ptr <= '0;
        end else if (word == IDLE) begin
          idle_out <= 1'b1;
        end else begin
          for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_ptr == LW'(l)) begin
              data_rx[l*WIDTH +: WIDTH] <= word;
              valid_rx[l]               <= 1'b1;
            end
          end
          lane_ptr <= (lane_ptr == LAST_LANE) ? '0 : lane_ptr + LANE_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_phy_deser_n.sv
// Testbench for phy_deser_n (WIDTH=8, NUM_LANES=4, LOCK_COUNT=4): directed byte vectors plus
// a randomized bit stream, both checked against a stream-level reference model.
module tb_phy_deser_n;

  localparam logic [7:0] K_COMMA = 8'hBC;
  localparam logic [7:0] K_IDLE  = 8'h7C;
  localparam int         K_LOCK  = 4;

  logic        clk_32f = 1'b0;
  logic        reset;
  logic        data_in;
  logic        resync;
  logic [31:0] data_rx;
  logic [3:0]  valid_rx;
  logic        active;
  logic        idle_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_32f = ~clk_32f;

  phy_deser_n #(
    .WIDTH      (8),
    .NUM_LANES  (4),
    .COMMA      (K_COMMA),
    .IDLE       (K_IDLE),
    .LOCK_COUNT (K_LOCK)
  ) dut (
    .clk_32f  (clk_32f),
    .reset    (reset),
    .data_in  (data_in),
    .resync   (resync),
    .data_rx  (data_rx),
    .valid_rx (valid_rx),
    .active   (active),
    .idle_out (idle_out)
  );

  // ---------------- reference model (stream level) ----------------
  typedef enum {M_HUNT, M_CONFIRM, M_LOCKED} mmode_t;
  mmode_t     m_mode;
  int         m_nbit;     // bits received since reset
  int         m_anchor;   // bit index where the first aligned comma completed
  int         m_commas;
  int         m_ptr;
  int         m_window;   // last 8 received bits
  logic [7:0] m_lane [4];
  logic [3:0] m_valid;
  logic       m_idle;

  task automatic model_reset();
    m_mode = M_HUNT; m_nbit = 0; m_anchor = 0; m_commas = 0; m_ptr = 0; m_window = 0;
    for (int i = 0; i < 4; i++) m_lane[i] = 8'h00;
    m_valid = 4'b0; m_idle = 1'b0;
  endtask

  task automatic model_step(input logic b, input logic rs);
    logic on_grid;
    m_nbit   = m_nbit + 1;
    m_window = ((m_window * 2) + int'(b)) % 256;
    m_valid  = 4'b0;
    m_idle   = 1'b0;
    on_grid  = ((m_nbit - m_anchor) % 8) == 0;
    if (rs) begin
      m_mode = M_HUNT; m_commas = 0; m_ptr = 0;
    end else if (m_mode == M_HUNT) begin
      if (m_window == int'(K_COMMA)) begin
        m_anchor = m_nbit; m_commas = 1;
        if (K_LOCK == 1) begin m_mode = M_LOCKED; m_ptr = 0; end
        else m_mode = M_CONFIRM;
      end
    end else if (m_mode == M_CONFIRM) begin
      if (on_grid) begin
        if (m_window == int'(K_COMMA)) begin
          m_commas = m_commas + 1;
          if (m_commas == K_LOCK) begin m_mode = M_LOCKED; m_ptr = 0; end
        end else begin
          m_mode = M_HUNT; m_commas = 0;
        end
      end
    end else begin
      if (on_grid) begin
        if (m_window == int'(K_COMMA)) m_ptr = 0;
        else if (m_window == int'(K_IDLE)) m_idle = 1'b1;
        else begin
          m_lane[m_ptr]  = 8'(m_window);
          m_valid[m_ptr] = 1'b1;
          m_ptr          = (m_ptr + 1) % 4;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("mdl_data",   data_rx, {m_lane[3], m_lane[2], m_lane[1], m_lane[0]});
    check("mdl_valid",  32'(valid_rx), 32'(m_valid));
    check("mdl_idle",   32'(idle_out), 32'(m_idle));
    check("mdl_active", 32'(active), 32'(m_mode == M_LOCKED));
  endtask

  // Entered at a negedge: drive the bit, let the DUT sample it, then compare at the next negedge.
  task automatic send_bit(input logic b, input logic rs);
    data_in = b;
    resync  = rs;
    @(posedge clk_32f);
    model_step(b, rs);
    @(negedge clk_32f);
    resync = 1'b0;
    check_model();
  endtask

  task automatic send_byte(input logic [7:0] v, input logic rs_last);
    for (int k = 7; k >= 0; k--) send_bit(v[k], rs_last && (k == 0));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0]  byt;
    logic        rs;
    logic [3:0]  valid;
    logic        idle;
    logic        act;
    logic [31:0] data;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [7:0] byt, input logic rs, input logic [3:0] valid,
                              input logic idle, input logic act, input logic [31:0] data);
    vec_t v;
    v.byt = byt; v.rs = rs; v.valid = valid; v.idle = idle; v.act = act; v.data = data;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // lock: 4 commas, active only after the 4th
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h00000000));
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h00000000));
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h00000000));
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h00000000));
    // round-robin lanes with wrap
    tbl.push_back(mk(8'h11, 1'b0, 4'b0001, 1'b0, 1'b1, 32'h00000011));
    tbl.push_back(mk(8'h22, 1'b0, 4'b0010, 1'b0, 1'b1, 32'h00002211));
    tbl.push_back(mk(8'h33, 1'b0, 4'b0100, 1'b0, 1'b1, 32'h00332211));
    tbl.push_back(mk(8'h44, 1'b0, 4'b1000, 1'b0, 1'b1, 32'h44332211));
    tbl.push_back(mk(8'h55, 1'b0, 4'b0001, 1'b0, 1'b1, 32'h44332255));
    // comma restarts lanes, idle pulses without moving the pointer
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h44332255));
    tbl.push_back(mk(8'h11, 1'b0, 4'b0001, 1'b0, 1'b1, 32'h44332211));
    tbl.push_back(mk(8'h7C, 1'b0, 4'b0000, 1'b1, 1'b1, 32'h44332211));
    tbl.push_back(mk(8'h22, 1'b0, 4'b0010, 1'b0, 1'b1, 32'h44332211));
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h44332211));
    tbl.push_back(mk(8'h33, 1'b0, 4'b0001, 1'b0, 1'b1, 32'h44332233));
    // resync on a data boundary: no strobe, lock drops, lanes kept
    tbl.push_back(mk(8'h66, 1'b1, 4'b0000, 1'b0, 1'b0, 32'h44332233));
    // two commas then a non-comma: falls back to search
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h44332233));
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h44332233));
    tbl.push_back(mk(8'hA5, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h44332233));
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h44332233));
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h44332233));
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h44332233));
    tbl.push_back(mk(8'hBC, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h44332233));
    tbl.push_back(mk(8'h77, 1'b0, 4'b0001, 1'b0, 1'b1, 32'h44332277));

    // reset state
    reset   = 1'b0;
    data_in = 1'b0;
    resync  = 1'b0;
    model_reset();
    #2;
    check("rst_data",   data_rx, 32'h0);
    check("rst_valid",  32'(valid_rx), 32'h0);
    check("rst_idle",   32'(idle_out), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    @(negedge clk_32f);
    reset = 1'b1;

    // three arbitrary bits ahead of the first comma
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      send_byte(tbl[i].byt, tbl[i].rs);
      check($sformatf("vec%0d_valid", i),  32'(valid_rx), 32'(tbl[i].valid));
      check($sformatf("vec%0d_idle", i),   32'(idle_out), 32'(tbl[i].idle));
      check($sformatf("vec%0d_active", i), 32'(active),   32'(tbl[i].act));
      check($sformatf("vec%0d_data", i),   data_rx,       tbl[i].data);
    end

    // reset partway through a word while locked
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    reset = 1'b0;
    #1;
    model_reset();
    check("midrst_data",   data_rx, 32'h0);
    check("midrst_valid",  32'(valid_rx), 32'h0);
    check("midrst_idle",   32'(idle_out), 32'h0);
    check("midrst_active", 32'(active), 32'h0);
    @(negedge clk_32f);
    @(negedge clk_32f);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 3; i++) send_byte(K_COMMA, 1'b0);
    check("relock_early_active", 32'(active), 32'h0);
    send_byte(K_COMMA, 1'b0);
    check("relock_active", 32'(active), 32'h1);
    send_byte(8'h5A, 1'b0);
    check("relock_valid", 32'(valid_rx), 32'h1);
    check("relock_data",  data_rx, 32'h0000005A);

    // randomized stream: commas, idles, data, bit slips and occasional resync
    for (int w = 0; w < 400; w++) begin
      logic [7:0] v;
      if (m_mode != M_LOCKED && $urandom_range(0, 9) < 7) v = K_COMMA;
      else begin
        case ($urandom_range(0, 9))
          0:       v = K_COMMA;
          1:       v = K_IDLE;
          default: v = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 29) == 0) begin
        for (int s = 0; s < int'($urandom_range(1, 7)); s++)
          send_bit(1'($urandom_range(0, 1)), 1'b0);
      end
      for (int k = 7; k >= 0; k--) send_bit(v[k], $urandom_range(0, 399) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
